// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I/RV64I control unit:
// FSM states, opcodes and the datapath select codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StDecode,
        StExecute,
        StMem,
        StWriteback,
        StTrap
    } state_e;

    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [2:0] BrNone    = 3'b000;
    localparam logic [2:0] BrNonZero = 3'b001;
    localparam logic [2:0] BrZero    = 3'b010;
    localparam logic [2:0] BrJal     = 3'b011;
    localparam logic [2:0] BrJalr    = 3'b100;

    localparam logic [2:0] ImmI  = 3'b000;
    localparam logic [2:0] ImmS  = 3'b001;
    localparam logic [2:0] ImmU  = 3'b010;
    localparam logic [2:0] ImmJ  = 3'b011;
    localparam logic [2:0] ImmB  = 3'b100;
    localparam logic [2:0] ImmIu = 3'b101;

    localparam logic [1:0] RegInImm = 2'b00;
    localparam logic [1:0] RegInAlu = 2'b01;
    localparam logic [1:0] RegInPc4 = 2'b10;

    localparam logic [1:0] AluAdd    = 2'b00;
    localparam logic [1:0] AluBranch = 2'b01;
    localparam logic [1:0] AluFunct  = 2'b10;

    typedef struct packed {
        logic       alu_r;
        logic       alu_i;
        logic       load;
        logic       store;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       lui;
        logic       auipc;
        logic       system;
        logic       illegal;
        logic [2:0] br;
        logic [2:0] imm;
        logic [1:0] regin;
    } dec_t;

    // BNE/BLT/BLTU take the branch when the ALU result is non-zero.
    function automatic logic [2:0] branch_code(input logic [2:0] f3);
        return (f3[0] ^ f3[2]) ? BrNonZero : BrZero;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct3 decoder: instruction class flags, immediate,
// branch and writeback-source codes, store byte enables and the illegal flag.
module mc_decode
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    localparam int unsigned STRB_W = XLEN / 8
) (
    input  logic [31:0]       instr,
    output dec_t              dec,
    output logic [STRB_W-1:0] strb
);

    localparam logic [2:0] StoreMax = (XLEN == 64) ? 3'd3 : 3'd2;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [3:0] nbytes;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign f3          = instr[14:12];
    assign unused_bits = ^{instr[31:15], instr[11:7]};

    always_comb begin
        dec    = '0;
        strb   = '0;
        nbytes = 4'd1 << f3[1:0];
        case (opcode)
            OpRType: begin
                dec.alu_r = 1'b1;
                dec.regin = RegInAlu;
            end
            OpIType: begin
                dec.alu_i = 1'b1;
                dec.imm   = ImmI;
                dec.regin = RegInAlu;
            end
            OpLoad: begin
                dec.load    = 1'b1;
                dec.imm     = f3[2] ? ImmIu : ImmI;
                dec.regin   = RegInAlu;
                dec.illegal = (f3 == 3'b111);
            end
            OpStore: begin
                dec.store   = 1'b1;
                dec.imm     = ImmS;
                dec.illegal = (f3 > StoreMax);
                // Unshifted enables; the datapath aligns them to the address.
                for (int i = 0; i < int'(STRB_W); i++) begin
                    strb[i] = (i < int'(nbytes));
                end
            end
            OpBranch: begin
                dec.branch  = 1'b1;
                dec.imm     = ImmB;
                dec.br      = branch_code(f3);
                dec.illegal = (f3[2:1] == 2'b01);
            end
            OpJal: begin
                dec.jal   = 1'b1;
                dec.imm   = ImmJ;
                dec.br    = BrJal;
                dec.regin = RegInPc4;
            end
            OpJalr: begin
                dec.jalr  = 1'b1;
                dec.imm   = ImmI;
                dec.br    = BrJalr;
                dec.regin = RegInPc4;
            end
            OpLui: begin
                dec.lui   = 1'b1;
                dec.imm   = ImmU;
                dec.regin = RegInImm;
            end
            OpAuipc: begin
                dec.auipc = 1'b1;
                dec.imm   = ImmU;
                dec.regin = RegInAlu;
            end
            OpSystem: dec.system = 1'b1;
            default:  dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback over
// a shared req/ack memory port, with a memory timeout and sticky trap causes.
module mc_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MEM_TIMEOUT = 16,
    localparam int unsigned STRB_W     = XLEN / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [STRB_W-1:0] mem_strb,
    output logic              ir_write,
    output logic              pc_write,
    output logic              pc_cond,
    output logic              regwrite,
    output logic              memtoreg,
    output logic [1:0]        alusrc,
    output logic [1:0]        aluop,
    output logic [2:0]        branch,
    output logic [1:0]        regin,
    output logic [2:0]        imm,
    output logic              illegal,
    output logic              bus_err,
    output logic              halted
);

    localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic              req_phase;
    logic              timeout;
    dec_t              dec;
    logic [STRB_W-1:0] dec_strb;

    mc_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr(instr),
        .dec  (dec),
        .strb (dec_strb)
    );

    assign req_phase = (state_q == StFetch) || (state_q == StMem);
    // The count reaches MEM_TIMEOUT this cycle; an ack in the same cycle wins.
    assign timeout   = (MEM_TIMEOUT != 0) && req_phase && !mem_ack && (cnt_q == CntLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StBoot;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            StBoot: state_d = StFetch;
            StFetch: begin
                if (mem_ack) begin
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d   = StTrap;
                    bus_err_d = 1'b1;
                end
            end
            StDecode: begin
                if (dec.illegal) begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end else if (dec.system) begin
                    state_d = StTrap;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                if (dec.load || dec.store) state_d = StMem;
                else if (dec.branch)       state_d = StFetch;
                else                       state_d = StWriteback;
            end
            StMem: begin
                if (mem_ack) begin
                    state_d = dec.load ? StWriteback : StFetch;
                end else if (timeout) begin
                    state_d   = StTrap;
                    bus_err_d = 1'b1;
                end
            end
            StWriteback: state_d = StFetch;
            StTrap:      state_d = StTrap;
            default:     state_d = StBoot;
        endcase

        if ((state_d != state_q) || mem_ack || !req_phase) cnt_d = '0;
        else                                                 cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_strb = '0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_cond  = 1'b0;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        alusrc   = 2'b00;
        aluop    = AluAdd;
        branch   = BrNone;
        regin    = RegInImm;
        imm      = ImmI;
        halted   = 1'b0;
        case (state_q)
            StFetch: begin
                mem_req  = 1'b1;
                ir_write = mem_ack;
                pc_write = mem_ack;
            end
            StExecute: begin
                alusrc   = {dec.auipc | dec.jal, dec.alu_i | dec.load | dec.store | dec.jalr};
                if (dec.alu_r || dec.alu_i) aluop = AluFunct;
                else if (dec.branch)        aluop = AluBranch;
                pc_cond  = dec.branch;
                pc_write = dec.jal | dec.jalr;
                branch   = dec.br;
                regin    = dec.regin;
                imm      = dec.imm;
            end
            StMem: begin
                mem_req = 1'b1;
                mem_we  = dec.store;
                if (dec.store) mem_strb = dec_strb;
            end
            StWriteback: begin
                regwrite = 1'b1;
                memtoreg = dec.load;
                regin    = dec.regin;
            end
            StTrap:  halted = 1'b1;
            default: ;
        endcase
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle output vectors against hand-derived
// expectations, with a 64-bit instance and a 32-bit shadow instance.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        mem_ack = 1'b0;

    logic       mem_req, mem_we, ir_write, pc_write, pc_cond, regwrite, memtoreg;
    logic       illegal, bus_err, halted;
    logic [7:0] mem_strb;
    logic [1:0] alusrc, aluop, regin;
    logic [2:0] branch, imm;

    logic       mem_req32, mem_we32, ir_write32, pc_write32, pc_cond32, regwrite32, memtoreg32;
    logic       illegal32, bus_err32, halted32;
    logic [3:0] mem_strb32;
    logic [1:0] alusrc32, aluop32, regin32;
    logic [2:0] branch32, imm32;

    logic [31:0] obs, obs32;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    logic [31:0] st_instr [4];
    logic [7:0]  st_strb  [4];

    always #5 clk = ~clk;

    mc_control #(.XLEN(64), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .instr(instr), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_strb(mem_strb), .ir_write(ir_write),
        .pc_write(pc_write), .pc_cond(pc_cond), .regwrite(regwrite), .memtoreg(memtoreg),
        .alusrc(alusrc), .aluop(aluop), .branch(branch), .regin(regin), .imm(imm),
        .illegal(illegal), .bus_err(bus_err), .halted(halted)
    );

    mc_control #(.XLEN(32), .MEM_TIMEOUT(4)) dut32 (
        .clk(clk), .reset(reset), .instr(instr), .mem_ack(mem_ack),
        .mem_req(mem_req32), .mem_we(mem_we32), .mem_strb(mem_strb32),
        .ir_write(ir_write32), .pc_write(pc_write32), .pc_cond(pc_cond32),
        .regwrite(regwrite32), .memtoreg(memtoreg32), .alusrc(alusrc32), .aluop(aluop32),
        .branch(branch32), .regin(regin32), .imm(imm32), .illegal(illegal32),
        .bus_err(bus_err32), .halted(halted32)
    );

    assign obs = {10'b0, mem_req, mem_we, ir_write, pc_write, pc_cond, regwrite, memtoreg,
                  alusrc, aluop, branch, regin, imm, illegal, bus_err, halted};
    assign obs32 = {10'b0, mem_req32, mem_we32, ir_write32, pc_write32, pc_cond32, regwrite32,
                    memtoreg32, alusrc32, aluop32, branch32, regin32, imm32, illegal32,
                    bus_err32, halted32};

    function automatic logic [31:0] ov(input logic req, we, irw, pcw, pcc, rw, m2r,
                                       input logic [1:0] asrc, aop, input logic [2:0] br,
                                       input logic [1:0] rin, input logic [2:0] im,
                                       input logic ill, berr, halt);
        return {10'b0, req, we, irw, pcw, pcc, rw, m2r, asrc, aop, br, rin, im, ill, berr, halt};
    endfunction

    function automatic logic [31:0] fetch_ov(input logic ack);
        return ov(1, 0, ack, ack, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, 0, 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle, then drive this cycle's inputs and let them settle.
    task automatic step(input logic [31:0] i, input logic a);
        @(posedge clk);
        #1;
        instr   = i;
        mem_ack = a;
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        #1;
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk("boot", obs, 32'h0);
        chk("boot_strb", {24'b0, mem_strb}, 32'h0);
    endtask

    localparam logic [31:0] IAdd  = 32'h002081B3;
    localparam logic [31:0] ILw   = 32'h0000A283;
    localparam logic [31:0] IBne  = 32'h00209063;
    localparam logic [31:0] IBeq  = 32'h00208063;
    localparam logic [31:0] IJalr = 32'h000100E7;
    localparam logic [31:0] IBad  = 32'h0000007F;
    localparam logic [31:0] IEcall = 32'h00000073;

    initial begin
        st_instr[0] = 32'h00208023; st_strb[0] = 8'h01;
        st_instr[1] = 32'h00209023; st_strb[1] = 8'h03;
        st_instr[2] = 32'h0020A023; st_strb[2] = 8'h0F;
        st_instr[3] = 32'h0020B023; st_strb[3] = 8'hFF;

        mem_ack = 1'b1;
        #2;
        do_reset();

        // ADD, zero-wait fetch
        step(IAdd, 1); chk("add_fetch", obs, fetch_ov(1));
        step(IAdd, 0); chk("add_dec", obs, 32'h0);
        step(IAdd, 0);
        chk("add_ex", obs, ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 2'b01, 3'b000, 0, 0, 0));
        step(IAdd, 0);
        chk("add_wb", obs, ov(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000, 0, 0, 0));
        step(IAdd, 0); chk("add_next_fetch", obs, fetch_ov(0));

        // LW, ack on the 4th memory cycle (count reaches the timeout, ack wins)
        step(ILw, 1); chk("lw_fetch", obs, fetch_ov(1));
        step(ILw, 0); chk("lw_dec", obs, 32'h0);
        step(ILw, 0);
        chk("lw_ex", obs, ov(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 2'b01, 3'b000, 0, 0, 0));
        for (int w = 0; w < 4; w++) begin
            step(ILw, (w == 3));
            chk("lw_mem", obs, ov(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, 0, 0));
            chk("lw_mem_strb", {24'b0, mem_strb}, 32'h0);
        end
        step(ILw, 0);
        chk("lw_wb", obs, ov(0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000, 0, 0, 0));

        // SB/SH/SW/SD; the 32-bit instance traps on SD
        for (int k = 0; k < 4; k++) begin
            step(st_instr[k], 1); chk("st_fetch", obs, fetch_ov(1));
            step(st_instr[k], 0); chk("st_dec", obs, 32'h0);
            step(st_instr[k], 0);
            chk("st_ex", obs, ov(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 2'b00, 3'b001, 0, 0, 0));
            if (k == 3) begin
                chk("sd32_trap", obs32,
                    ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1, 0, 1));
            end
            step(st_instr[k], 1);
            chk("st_mem", obs, ov(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, 0, 0));
            chk("st_strb", {24'b0, mem_strb}, {24'b0, st_strb[k]});
            if (k < 3) chk("st32_strb", {28'b0, mem_strb32}, {28'b0, st_strb[k][3:0]});
        end

        // BNE, BEQ, JALR; each fetch follows directly after the previous execute
        step(IBne, 1); chk("bne_fetch", obs, fetch_ov(1));
        step(IBne, 0); chk("bne_dec", obs, 32'h0);
        step(IBne, 0);
        chk("bne_ex", obs, ov(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 3'b001, 2'b00, 3'b100, 0, 0, 0));
        step(IBeq, 1); chk("beq_fetch", obs, fetch_ov(1));
        step(IBeq, 0); chk("beq_dec", obs, 32'h0);
        step(IBeq, 0);
        chk("beq_ex", obs, ov(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 3'b010, 2'b00, 3'b100, 0, 0, 0));
        step(IJalr, 1); chk("jalr_fetch", obs, fetch_ov(1));
        step(IJalr, 0); chk("jalr_dec", obs, 32'h0);
        step(IJalr, 0);
        chk("jalr_ex", obs, ov(0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 3'b100, 2'b10, 3'b000, 0, 0, 0));
        step(IJalr, 0);
        chk("jalr_wb", obs, ov(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 2'b10, 3'b000, 0, 0, 0));
        step(IJalr, 0); chk("jalr_next_fetch", obs, fetch_ov(0));

        // Illegal opcode traps and ignores mem_ack
        step(IBad, 1); chk("bad_fetch", obs, fetch_ov(1));
        step(IBad, 1); chk("bad_dec", obs, 32'h0);
        step(IBad, 1);
        chk("bad_trap", obs, ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1, 0, 1));
        step(IBad, 1);
        chk("bad_trap_hold", obs, ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1, 0, 1));
        do_reset();

        // ECALL traps without the illegal flag
        step(IEcall, 1); chk("ecall_fetch", obs, fetch_ov(1));
        step(IEcall, 1); chk("ecall_dec", obs, 32'h0);
        step(IEcall, 1);
        chk("ecall_trap", obs, ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, 0, 1));
        step(IEcall, 1);
        chk("ecall_hold", obs, ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, 0, 1));
        do_reset();

        // Fetch timeout after 4 wait cycles
        for (int w = 0; w < 4; w++) begin
            step(IAdd, 0); chk("to_fetch_wait", obs, fetch_ov(0));
        end
        step(IAdd, 0);
        chk("to_trap", obs, ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, 1, 1));
        step(IAdd, 1);
        chk("to_trap_hold", obs, ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, 1, 1));
        do_reset();

        // Ack on the 4th wait cycle completes normally
        for (int w = 0; w < 3; w++) begin
            step(IAdd, 0); chk("ack4_wait", obs, fetch_ov(0));
        end
        step(IAdd, 1); chk("ack4_fetch", obs, fetch_ov(1));
        step(IAdd, 0); chk("ack4_dec", obs, 32'h0);
        step(IAdd, 0);
        chk("ack4_ex", obs, ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 2'b01, 3'b000, 0, 0, 0));
        step(IAdd, 0);
        step(IAdd, 0); chk("midreq_fetch", obs, fetch_ov(0));
        // Reset in the middle of a pending fetch drops mem_req at once
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
